// File: rtl/softmax_pkg.sv
// softmax_pkg
// Shared definitions for the softmax division sequencer:
//   DATA_W / DEN_W   : exponent/probability width and divisor width
//   sched_state_t    : sequencer states LOAD -> SCALE -> DIV -> LOAD
//   prob_t           : unsigned 0.8 fixed-point probability
//   apply_overrides  : corner-case fix-up of the raw divider quotient
package softmax_pkg;

  localparam int DATA_W = 8;
  localparam int DEN_W  = 9;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SCALE = 2'd1,
    DIV   = 2'd2
  } sched_state_t;

  typedef logic [DATA_W-1:0] prob_t;

  // The raw divider result is only meaningful for num < den. A zero sum
  // gives probability 0, and a numerator equal to the (nonzero) scaled sum
  // saturates to the largest representable fraction.
  function automatic prob_t apply_overrides(input logic [DATA_W-1:0] num,
                                            input logic [DEN_W-1:0]  den,
                                            input prob_t             qh);
    prob_t q;
    if (den == {DEN_W{1'b0}}) begin
      q = 8'h00;
    end else if ({1'b0, num} == den) begin
      q = 8'hFF;
    end else begin
      q = qh;
    end
    return q;
  endfunction

endpackage

// File: rtl/softmax_div_sched_array_divider.sv
// array_divider
// Combinational restoring array divider producing the 8 fractional quotient
// bits of x/y, i.e. floor(256*x/y). The result is valid for x < y only; the
// sequencer overrides the x >= y and y == 0 cases.
// Ports:
//   x_i  : numerator, DATA_W bits
//   y_i  : divisor, DEN_W bits
//   qh_o : fractional quotient (0.8 fixed point)
module array_divider
  import softmax_pkg::*;
(
  input  logic [DATA_W-1:0] x_i,
  input  logic [DEN_W-1:0]  y_i,
  output prob_t             qh_o
);

  // One compare/subtract row per quotient bit, MSB first. With x < y the
  // partial remainder stays below y, so doubling it needs only one extra bit.
  always_comb begin
    logic [DEN_W-1:0] rem;
    logic [DEN_W:0]   trial;
    qh_o  = 8'h00;
    rem   = {1'b0, x_i};
    trial = {(DEN_W+1){1'b0}};
    for (int i = DATA_W - 1; i >= 0; i--) begin
      trial = {rem, 1'b0};
      if (trial >= {1'b0, y_i}) begin
        qh_o[i] = 1'b1;
        rem     = DEN_W'(trial - {1'b0, y_i});
      end else begin
        qh_o[i] = 1'b0;
        rem     = trial[DEN_W-1:0];
      end
    end
  end

endmodule

// File: rtl/softmax_div_sched.sv
// softmax_div_sched
// Softmax normalisation sequencer. Collects N exponent values, sums them,
// right-shifts sum and numerators so the sum fits a 9-bit divisor, then
// streams every element through one shared array_divider as 0.8 fixed-point
// probabilities.
// Parameters:
//   N     : elements per vector, power of two, 2..64
//   SUM_W : accumulator width (derived)
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready    : exponent input handshake (ready only in LOAD)
//   in_data              : unsigned exponent value
//   out_valid/out_ready  : probability output handshake
//   out_data             : probability, unsigned 0.8 fixed point
//   out_last             : marks element N-1 (only with SOFTMAX_SCHED_LAST_EN)
// Build option: define SOFTMAX_SCHED_LAST_EN to add the out_last port.
module softmax_div_sched
  import softmax_pkg::*;
#(
  parameter  int N     = 4,
  localparam int SUM_W = DATA_W + $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output prob_t             out_data
`ifdef SOFTMAX_SCHED_LAST_EN
  ,
  output logic              out_last
`endif
);

  localparam int IDX_W = $clog2(N);
  // rd_idx needs one extra bit so "all N elements issued" is representable.
  localparam int RD_W  = IDX_W + 1;
  localparam int K_W   = $clog2(SUM_W);

  sched_state_t      state_q, state_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
  logic [RD_W-1:0]   rd_idx_q, rd_idx_d;
  logic [K_W-1:0]    k_q, k_d;
  logic [DEN_W-1:0]  den_q, den_d;
  logic              out_valid_q, out_valid_d;
  prob_t             out_data_q, out_data_d;
  logic              out_last_q, out_last_d;

  logic [DATA_W-1:0] buf_q [N];

  logic              in_ready_s;
  logic              wr_en_s;
  logic [SUM_W:0]    sum_ext_s;
  logic [K_W-1:0]    k_s;
  logic [DEN_W-1:0]  den_s;
  logic [IDX_W-1:0]  rd_ptr_s;
  logic [DATA_W-1:0] num_s;
  prob_t             qh_s;
  prob_t             q_s;
  logic              out_hs_s;
  logic              load_s;

  assign in_ready_s = (state_q == LOAD);
  assign wr_en_s    = in_ready_s & in_valid & ~rst;
  assign sum_ext_s  = {1'b0, sum_q};
  assign rd_ptr_s   = rd_idx_q[IDX_W-1:0];
  assign num_s      = DATA_W'(buf_q[rd_ptr_s] >> k_q);
  assign out_hs_s   = out_valid_q & out_ready;
  // Load the output register when it is empty or being drained, as long as
  // elements remain to be issued for this vector.
  assign load_s     = (state_q == DIV) && (rd_idx_q != RD_W'(N)) &&
                      (!out_valid_q || out_ready);

  // Smallest shift k with (sum >> k) < 512: one past the largest shift that
  // still leaves the sum at or above 512.
  always_comb begin
    k_s = {K_W{1'b0}};
    for (int j = 0; j < SUM_W; j++) begin
      if ((sum_ext_s >> j) >= (SUM_W+1)'(512)) begin
        k_s = K_W'(j + 1);
      end else begin
        k_s = k_s;
      end
    end
  end

  assign den_s = DEN_W'(sum_q >> k_s);

  array_divider u_div (
    .x_i  (num_s),
    .y_i  (den_q),
    .qh_o (qh_s)
  );

  assign q_s = apply_overrides(num_s, den_q, qh_s);

  // Next-state and datapath control for the LOAD/SCALE/DIV sequence.
  always_comb begin
    state_d     = state_q;
    sum_d       = sum_q;
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;
    k_d         = k_q;
    den_d       = den_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    case (state_q)
      LOAD: begin
        if (in_valid) begin
          sum_d    = sum_q + SUM_W'(in_data);
          wr_idx_d = wr_idx_q + IDX_W'(1);
          if (wr_idx_q == IDX_W'(N - 1)) begin
            state_d = SCALE;
          end else begin
            state_d = LOAD;
          end
        end else begin
          state_d = LOAD;
        end
      end
      SCALE: begin
        k_d     = k_s;
        den_d   = den_s;
        state_d = DIV;
      end
      DIV: begin
        if (load_s) begin
          out_valid_d = 1'b1;
          out_data_d  = q_s;
          out_last_d  = (rd_idx_q == RD_W'(N - 1));
          rd_idx_d    = rd_idx_q + RD_W'(1);
        end else if (out_hs_s) begin
          out_valid_d = 1'b0;
        end else begin
          out_valid_d = out_valid_q;
        end
        // The final element drains without a refill, so the output register
        // is already being emptied above when the vector completes here.
        if (out_hs_s && out_last_q) begin
          state_d    = LOAD;
          sum_d      = {SUM_W{1'b0}};
          wr_idx_d   = {IDX_W{1'b0}};
          rd_idx_d   = {RD_W{1'b0}};
          out_last_d = 1'b0;
        end else begin
          state_d = DIV;
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  // Sequencer state, accumulator, indices, scale factors and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOAD;
      sum_q       <= {SUM_W{1'b0}};
      wr_idx_q    <= {IDX_W{1'b0}};
      rd_idx_q    <= {RD_W{1'b0}};
      k_q         <= {K_W{1'b0}};
      den_q       <= {DEN_W{1'b0}};
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      k_q         <= k_d;
      den_q       <= den_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  // Element buffer; contents survive reset and are simply overwritten.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      buf_q[wr_idx_q] <= in_data;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
`ifdef SOFTMAX_SCHED_LAST_EN
  assign out_last  = out_last_q;
`endif

endmodule

// File: tb/tb_softmax_div_sched.sv
module tb_softmax_div_sched;

  localparam int N = 4;
  typedef logic [7:0] vec_t [4];

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
`ifdef SOFTMAX_SCHED_LAST_EN
  logic       out_last;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  softmax_div_sched #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef SOFTMAX_SCHED_LAST_EN
    ,
    .out_last  (out_last)
`endif
  );

  // Reference: softmax normalisation computed directly with integer maths.
  function automatic void model(input vec_t v, output vec_t e);
    int sum, k, den, num;
    sum = 0;
    for (int i = 0; i < N; i++) sum += int'(v[i]);
    k = 0;
    while ((sum >> k) >= 512) k++;
    den = sum >> k;
    for (int i = 0; i < N; i++) begin
      num = int'(v[i]) >> k;
      if (den == 0)        e[i] = 8'd0;
      else if (num == den) e[i] = 8'd255;
      else                 e[i] = 8'((num * 256) / den);
    end
  endfunction

  // Present one full vector; starts and ends at a falling edge.
  task automatic send_vec(input vec_t v);
    int g;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = v[i];
      g = 0;
      while (!in_ready && g < 50) begin
        @(negedge clk);
        g++;
      end
      n_checks++;
      if (g >= 50) begin
        n_fail++;
        $display("FAIL send_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, g);
      end
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  // Drain n outputs with random stalls; starts and ends at a falling edge.
  task automatic collect(input int n, input int stall_pct, output vec_t got, output logic [3:0] lasts);
    int cnt, g;
    cnt = 0;
    g = 0;
    got = '{default: 8'h00};
    lasts = 4'b0000;
    while (cnt < n && g < 200) begin
      out_ready = (int'($urandom_range(99)) >= stall_pct);
      if (out_valid && out_ready) begin
        got[cnt] = out_data;
`ifdef SOFTMAX_SCHED_LAST_EN
        lasts[cnt] = out_last;
`endif
        cnt++;
      end
      @(posedge clk);
      @(negedge clk);
      g++;
    end
    out_ready = 1'b1;
    n_checks++;
    if (cnt != n) begin
      n_fail++;
      $display("FAIL collect_timeout: got %0d outputs, required %0d", cnt, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data: got %0d required 0", out_data); end
`ifdef SOFTMAX_SCHED_LAST_EN
    n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last: got %b required 0", out_last); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_uniform();
    vec_t v, got, ex;
    logic [3:0] l;
    v  = '{8'd64, 8'd64, 8'd64, 8'd64};
    ex = '{8'd64, 8'd64, 8'd64, 8'd64};
    send_vec(v);
    // Now just after the final accept edge: state is SCALE.
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL latency_t0: out_valid=%b in_ready=%b required 0 0", out_valid, in_ready); end
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL latency_t1: out_valid=%b required 0", out_valid); end
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL latency_t2: out_valid=%b required 1", out_valid); end
    collect(4, 0, got, l);
    for (int i = 0; i < N; i++) begin
      n_checks++; if (got[i] !== ex[i]) begin n_fail++; $display("FAIL uniform_out[%0d]: got %0d required %0d", i, got[i], ex[i]); end
    end
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL uniform_return: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid); end
  endtask

  task automatic test_saturated_inputs();
    vec_t v, got;
    logic [3:0] l;
    v = '{8'd255, 8'd255, 8'd255, 8'd255};
    send_vec(v);
    collect(4, 0, got, l);
    for (int i = 0; i < N; i++) begin
      n_checks++; if (got[i] !== 8'd63) begin n_fail++; $display("FAIL shift_out[%0d]: got %0d required 63", i, got[i]); end
    end
  endtask

  task automatic test_overrides();
    vec_t v, got, ex;
    logic [3:0] l;
    v  = '{8'd0, 8'd0, 8'd200, 8'd0};
    ex = '{8'd0, 8'd0, 8'd255, 8'd0};
    send_vec(v);
    collect(4, 0, got, l);
    for (int i = 0; i < N; i++) begin
      n_checks++; if (got[i] !== ex[i]) begin n_fail++; $display("FAIL eq_override[%0d]: got %0d required %0d", i, got[i], ex[i]); end
    end
    v = '{8'd0, 8'd0, 8'd0, 8'd0};
    send_vec(v);
    collect(4, 0, got, l);
    for (int i = 0; i < N; i++) begin
      n_checks++; if (got[i] !== 8'd0) begin n_fail++; $display("FAIL zero_override[%0d]: got %0d required 0", i, got[i]); end
    end
  endtask

  task automatic test_backpressure();
    vec_t v, got, ex;
    logic [3:0] l;
    int g;
    v  = '{8'd20, 8'd50, 8'd90, 8'd140};
    ex = '{8'd17, 8'd42, 8'd76, 8'd119};
    out_ready = 1'b1;
    send_vec(v);
    // Junk on the input while not in LOAD must be ignored.
    in_valid = 1'b1; in_data = 8'hAA;
    g = 0;
    while (!out_valid && g < 20) begin @(negedge clk); g++; end
    n_checks++; if (out_data !== ex[0]) begin n_fail++; $display("FAIL bp_elem0: got %0d required %0d", out_data, ex[0]); end
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== ex[1] || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: valid=%b data=%0d in_ready=%b required 1 %0d 0", c, out_valid, out_data, in_ready, ex[1]);
      end
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    collect(3, 0, got, l);
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (got[i] !== ex[i+1]) begin n_fail++; $display("FAIL bp_out[%0d]: got %0d required %0d", i + 1, got[i], ex[i+1]); end
    end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_return: in_ready=%b required 1", in_ready); end
  endtask

  task automatic test_reset_mid();
    vec_t v, got, ex;
    logic [3:0] l;
    // Partial vector, then reset: those two values must be discarded.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); in_valid = 1'b1; in_data = 8'd250;
      @(posedge clk);
    end
    @(negedge clk); in_valid = 1'b0; rst = 1'b1;
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    v  = '{8'd200, 8'd100, 8'd50, 8'd25};
    ex = '{8'd136, 8'd68, 8'd34, 8'd17};
    send_vec(v);
    collect(2, 0, got, l);
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (got[i] !== ex[i]) begin n_fail++; $display("FAIL load_reset_out[%0d]: got %0d required %0d", i, got[i], ex[i]); end
    end
    // Reset in the middle of DIV.
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 8'h00) begin
      n_fail++;
      $display("FAIL div_reset: out_valid=%b in_ready=%b out_data=%0d required 0 1 0", out_valid, in_ready, out_data);
    end
    rst = 1'b0;
    v  = '{8'd10, 8'd30, 8'd60, 8'd100};
    ex = '{8'd12, 8'd38, 8'd76, 8'd128};
    send_vec(v);
    collect(4, 0, got, l);
    for (int i = 0; i < N; i++) begin
      n_checks++; if (got[i] !== ex[i]) begin n_fail++; $display("FAIL after_reset_out[%0d]: got %0d required %0d", i, got[i], ex[i]); end
    end
  endtask

  task automatic test_random();
    vec_t v, got, ex;
    logic [3:0] l;
    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(3) == 0) v[i] = 8'($urandom_range(15));
        else                        v[i] = 8'($urandom_range(255));
      end
      model(v, ex);
      send_vec(v);
      collect(4, 40, got, l);
      for (int i = 0; i < N; i++) begin
        n_checks++;
        if (got[i] !== ex[i]) begin
          n_fail++;
          $display("FAIL random[%0d][%0d]: in=%0d,%0d,%0d,%0d got %0d required %0d", t, i, v[0], v[1], v[2], v[3], got[i], ex[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t v, got, ex;
    logic [3:0] l;
    for (int t = 0; t < 2; t++) begin
      for (int i = 0; i < N; i++) v[i] = 8'($urandom_range(1, 255));
      model(v, ex);
      send_vec(v);
      collect(4, 0, got, l);
      for (int i = 0; i < N; i++) begin
        n_checks++; if (got[i] !== ex[i]) begin n_fail++; $display("FAIL b2b[%0d][%0d]: got %0d required %0d", t, i, got[i], ex[i]); end
      end
`ifdef SOFTMAX_SCHED_LAST_EN
      n_checks++; if (l !== 4'b1000) begin n_fail++; $display("FAIL b2b_last[%0d]: got %b required 1000", t, l); end
`endif
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_uniform();
    test_saturated_inputs();
    test_overrides();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
